// File: rtl/load_scoreboard.sv
// Per-register load-use scoreboard: one countdown per load destination, ID stalls
// only while a source (or a WAW destination) still has a load result in flight.

module load_scoreboard_cnt #(
  parameter int CW  = 2,
  parameter int LAT = 3
) (
  input  logic iw_clk_i,
  input  logic iw_rst_ni,
  input  logic flush_i,
  input  logic set_i,
  output logic busy_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  // Flush beats a same-cycle set, so a killed load never leaves a count behind.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)             cnt_d = '0;
    else if (set_i)          cnt_d = CW'(LAT);
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge iw_clk_i or negedge iw_rst_ni) begin
    if (!iw_rst_ni) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
endmodule

module load_scoreboard #(
  parameter int NREG = 32,
  parameter int REGW = 5,
  parameter int LAT  = 3
) (
  input  logic            iw_clk,
  input  logic            iw_rst_n,
  input  logic            iw_issue_valid,
  input  logic            iw_issue_is_load,
  input  logic [REGW-1:0] iw_issue_rd,
  input  logic            iw_src_a_en,
  input  logic [REGW-1:0] iw_src_a,
  input  logic            iw_src_b_en,
  input  logic [REGW-1:0] iw_src_b,
  input  logic            iw_flush,
  output logic            ow_stall,
  output logic [NREG-1:0] ow_busy,
  output logic [15:0]     ow_stall_cycles
);
  localparam int CW = $clog2(LAT + 1);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set;
  logic            hit_a, hit_b, hit_d, acc;
  logic [15:0]     stall_cycles_q, stall_cycles_d;

  // Index decode by compare: indices >= NREG match nothing, so they are untracked.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    hit_d = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (busy[r] && iw_src_a == REGW'(r)) hit_a = iw_src_a_en;
      if (busy[r] && iw_src_b == REGW'(r)) hit_b = iw_src_b_en;
      if (busy[r] && iw_issue_rd == REGW'(r)) hit_d = iw_issue_is_load;
    end
  end

  assign ow_stall = iw_issue_valid & (hit_a | hit_b | hit_d);
  assign acc      = iw_issue_valid & ~ow_stall;

  for (genvar r = 0; r < NREG; r++) begin : gen_cnt
    assign set[r] = acc & iw_issue_is_load & (iw_issue_rd == REGW'(r));
    load_scoreboard_cnt #(.CW(CW), .LAT(LAT)) u_cnt (
      .iw_clk_i (iw_clk),
      .iw_rst_ni(iw_rst_n),
      .flush_i  (iw_flush),
      .set_i    (set[r]),
      .busy_o   (busy[r])
    );
  end

  // Stalls that coincide with a flush are not real lost cycles; skip them.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (ow_stall && !iw_flush && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) stall_cycles_q <= '0;
    else           stall_cycles_q <= stall_cycles_d;
  end

  assign ow_busy         = busy;
  assign ow_stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_load_scoreboard.sv
// Scoreboard bench for load_scoreboard: a timestamp model predicts every cycle,
// a negedge monitor pops predictions and compares against the DUT.
module tb_load_scoreboard;
  localparam int NREG = 28;
  localparam int REGW = 5;
  localparam int LAT  = 3;

  typedef struct {
    logic            stall;
    logic [NREG-1:0] busy;
    logic [15:0]     sc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid, issue_is_load, src_a_en, src_b_en, flush;
  logic [REGW-1:0] issue_rd, src_a, src_b;
  logic            stall;
  logic [NREG-1:0] busy;
  logic [15:0]     stall_cycles;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t q[$];

  // Model: a register is busy while the current cycle is before its ready time.
  longint cyc = 0;
  longint rdy [NREG];
  int     sc_m = 0;

  load_scoreboard #(.NREG(NREG), .REGW(REGW), .LAT(LAT)) dut (
    .iw_clk(clk), .iw_rst_n(rst_n),
    .iw_issue_valid(issue_valid), .iw_issue_is_load(issue_is_load), .iw_issue_rd(issue_rd),
    .iw_src_a_en(src_a_en), .iw_src_a(src_a), .iw_src_b_en(src_b_en), .iw_src_b(src_b),
    .iw_flush(flush), .ow_stall(stall), .ow_busy(busy), .ow_stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic m_busy(input logic [REGW-1:0] i);
    return (int'(i) < NREG) && (cyc < rdy[int'(i)]);
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", stall, e.stall);
      chk("busy", busy, e.busy);
      chk("stall_cycles", stall_cycles, e.sc);
    end
  end

  task automatic clear_model();
    for (int r = 0; r < NREG; r++) rdy[r] = 0;
  endtask

  // Present one ID cycle, predict outputs, then advance the model across the edge.
  task automatic step(input logic v, input logic ld, input logic [REGW-1:0] rd,
                      input logic ae, input logic [REGW-1:0] a,
                      input logic be, input logic [REGW-1:0] b, input logic fl);
    exp_t e;
    issue_valid = v; issue_is_load = ld; issue_rd = rd;
    src_a_en = ae; src_a = a; src_b_en = be; src_b = b; flush = fl;
    e.stall = v && ((ae && m_busy(a)) || (be && m_busy(b)) || (ld && m_busy(rd)));
    for (int r = 0; r < NREG; r++) e.busy[r] = (cyc < rdy[r]);
    e.sc = 16'(sc_m);
    q.push_back(e);
    @(posedge clk);
    cyc++;
    if (fl) clear_model();
    else if (v && !e.stall && ld && int'(rd) < NREG) rdy[int'(rd)] = cyc + LAT;
    if (e.stall && !fl && sc_m < 65535) sc_m++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    issue_valid = 1; issue_is_load = 1; issue_rd = '1;
    src_a_en = 1; src_a = '1; src_b_en = 1; src_b = '1; flush = 1;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sc", stall_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(3);
    chk("idle_sc", stall_cycles, 0);

    // Load-use directly behind: 3 stalls, accepted on the 4th cycle.
    step(1, 1, 5, 0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 1, 5, 0, 0, 0);
    chk("loaduse_sc", stall_cycles, 3);

    // Distance 2: 2 stalls.
    step(1, 1, 7, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 1, 7, 0);
    chk("dist2_sc", stall_cycles, 5);

    // Distance 4: no stall; busy[7] 1,1,1,0.
    step(1, 1, 7, 0, 0, 0, 0, 0);
    chk("busy7_c1", busy[7], 1);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    chk("busy7_c2", busy[7], 1);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    chk("busy7_c3", busy[7], 1);
    step(1, 0, 0, 1, 1, 0, 0, 0);
    chk("busy7_c4", busy[7], 0);
    step(1, 0, 0, 0, 0, 1, 7, 0);
    chk("dist4_sc", stall_cycles, 5);

    // WAW: cnt[9]=2 then a load to r9 stalls 2 cycles and re-arms.
    step(1, 1, 9, 0, 0, 0, 0, 0);
    idle(1);
    repeat (3) step(1, 1, 9, 0, 0, 0, 0, 0);
    chk("waw_busy9", busy[9], 1);
    chk("waw_sc", stall_cycles, 7);
    idle(3);
    chk("waw_drained", busy[9], 0);

    // Self-reference on an idle scoreboard: no stall.
    step(1, 1, 4, 1, 4, 0, 0, 0);
    chk("selfref_sc", stall_cycles, 7);
    chk("selfref_busy4", busy[4], 1);
    idle(3);

    // Flush with a dependent in ID: not counted, busy cleared.
    step(1, 1, 3, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 3, 0, 0, 1);
    chk("flush_busy", busy, 0);
    step(1, 0, 0, 1, 3, 0, 0, 0);
    chk("flush_sc", stall_cycles, 7);

    // Load accept together with flush: nothing left armed.
    step(1, 1, 6, 0, 0, 0, 0, 1);
    chk("ldflush_busy6", busy[6], 0);

    // Untracked index: load to r30 sets nothing, read of r30 never stalls.
    step(1, 1, 30, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 30, 1, 30, 0);
    chk("untracked_busy", busy, 0);
    chk("untracked_sc", stall_cycles, 7);

    // Saturation: preload 0xFFFE, then three stall cycles.
    force dut.stall_cycles_q = 16'hFFFE;
    #1;
    release dut.stall_cycles_q;
    sc_m = 16'hFFFE;
    step(1, 1, 10, 0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 1, 10, 0, 0, 0);
    chk("sat_sc", stall_cycles, 16'hFFFF);

    // Reset mid-countdown with a dependent in ID.
    step(1, 1, 2, 0, 0, 0, 0, 0);
    idle(1);
    chk("pre_rst_busy2", busy[2], 1);
    issue_valid = 1; issue_is_load = 0; src_a_en = 1; src_a = 2; flush = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_sc", stall_cycles, 0);
    rst_n = 1'b1;
    clear_model();
    sc_m = 0;
    step(1, 0, 0, 1, 2, 0, 0, 0);

    // Randomized traffic, biased to a few registers so hazards are frequent.
    for (int i = 0; i < 1500; i++) begin
      logic [REGW-1:0] rd, a, b;
      rd = ($urandom_range(0, 15) == 0) ? REGW'($urandom) : REGW'($urandom_range(0, 7));
      a  = ($urandom_range(0, 15) == 0) ? REGW'($urandom) : REGW'($urandom_range(0, 7));
      b  = REGW'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rd,
           $urandom_range(0, 1) == 1, a, $urandom_range(0, 1) == 1, b,
           $urandom_range(0, 29) == 0);
    end

    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/load_scoreboard.md
# load_scoreboard

Per-register load-use scoreboard for the in-order pipeline. It replaces the blanket "stall on any load" scheme: each load destination (`LDu` GPR or `SRLDu` special register) gets a countdown timer, and the ID stage stalls only while an instruction reads a register whose load result is not yet forwardable. It sits beside the ID/EX register, is driven by the decoder, and its `ow_stall` gates the IF/ID and ID/EX enables.

## Interface
Parameters:
- `NREG`, 32: number of tracked registers; the decoder maps GPRs and special registers into one index space.
- `REGW`, 5: index width, `2**REGW >= NREG`.
- `LAT`, 3: stall cycles for a dependent instruction directly behind a load, range 1..7.

Ports:
- `iw_clk`  in  1  clock; all state updates on the rising edge.
- `iw_rst_n`  in  1  asynchronous, active-low reset.
- `iw_issue_valid`  in  1  the ID instruction is valid this cycle.
- `iw_issue_is_load`  in  1  the ID instruction is `LDu` or `SRLDu`.
- `iw_issue_rd`  in  REGW  load destination index.
- `iw_src_a_en`  in  1  source A is read.
- `iw_src_a`  in  REGW  source A index.
- `iw_src_b_en`  in  1  source B is read.
- `iw_src_b`  in  REGW  source B index.
- `iw_flush`  in  1  pipeline flush; all in-flight loads are killed.
- `ow_stall`  out  1  hold ID; combinational from state and the ID inputs.
- `ow_busy`  out  NREG  bit r set while `cnt[r] != 0`; registered.
- `ow_stall_cycles`  out  16  saturating count of stalled cycles.

## Operation
- State: `cnt[r]`, one per register, `CW = clog2(LAT+1)` bits each; `ow_stall_cycles` counter.
- Hit condition: `hit_a = iw_src_a_en & (cnt[iw_src_a] != 0)`; `hit_b` is formed the same way from source B.
- WAW condition: `hit_d = iw_issue_is_load & (cnt[iw_issue_rd] != 0)`.
- Stall: `ow_stall = iw_issue_valid & (hit_a | hit_b | hit_d)`.
- Accept: `acc = iw_issue_valid & ~ow_stall`.
- Per-register update, in priority order:
  - `iw_flush`: `cnt[r] <= 0`.
  - `acc & iw_issue_is_load & r == iw_issue_rd`: `cnt[r] <= LAT`.
  - `cnt[r] != 0`: `cnt[r] <= cnt[r] - 1`.
  - Otherwise `cnt[r]` holds.
- Indices `>= NREG` never hit and never set; they are treated as not tracked.
- A load that reads its own destination as a source is checked against the old `cnt` only.
- `ow_stall_cycles` increments by 1 on each edge where `ow_stall == 1` and `iw_flush == 0`. It saturates at 0xFFFF and is cleared only by reset.
- `ow_busy[r] = (cnt[r] != 0)`, taken from the state registers.

## Timing
- Reset, asynchronous on `iw_rst_n` low: all `cnt` = 0, `ow_busy` = 0, `ow_stall_cycles` = 0.
  - `ow_stall` is 0 during reset regardless of inputs.
  - The first update happens at the first rising edge after `iw_rst_n` goes high.
- Reset asserted mid-countdown clears all state immediately. A dependent instruction then sees no stall; the pipeline is reset too.
- Load accepted at edge t: `cnt = LAT` after t. A dependent instruction in ID stalls for exactly LAT cycles and is accepted at edge t+LAT+1.
- A dependent instruction k cycles behind the load (1 <= k <= LAT) stalls for LAT-k+1 cycles. For k > LAT there is no stall.
- Stall-to-release is immediate: `ow_stall` drops in the same cycle `cnt` reaches 0, with no extra bubble.
- Flush and load accept in the same cycle: flush wins, and the counter ends at 0.
- Flush while stalled: `ow_stall` may be 1 in that cycle, but the stall counter does not increment. `ow_stall` is 0 in the next cycle.
- Back-to-back loads to different registers: each counter is independent, and both can be nonzero at once.

## Test plan
- Reset: `iw_rst_n` = 0 with all inputs at 1 → `ow_stall` = 0, `ow_busy` = 0, `ow_stall_cycles` = 0. After release, an idle `iw_issue_valid` = 0 produces no change.
- Load-use, LAT=3: accept a load with rd=5, then a source-A read of r5 in the next cycle → `ow_stall` = 1 for 3 cycles, accept on the 4th cycle, `ow_stall_cycles` = 3.
- Distance: load rd=7, one independent instruction, then a source-B read of r7 → 2 stall cycles. With three independent instructions in between → 0 stall cycles. `ow_busy[7]` reads 1,1,1,0 across the four cycles after the load.
- WAW and self-reference: while `cnt[9]=2`, issue a load with rd=9 → stalls for 2 cycles, then is accepted and `cnt[9]` = 3. A load with rd=4 and src_a=4 on an idle scoreboard → no stall.
- Flush: load rd=3 accepted, flush in the next cycle while a dependent instruction is in ID → `ow_busy` = 0 in the following cycle, no further stall, `ow_stall_cycles` unchanged. Load accept together with flush → `cnt` = 0.
- Saturation and reset mid-countdown: preload the counter to 0xFFFE, then force 3 stall cycles → the counter reads 0xFFFF. Assert `iw_rst_n` while `cnt[2]=2` → `ow_busy` = 0 and `ow_stall` = 0 immediately.
